// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle RV32I-subset core: fetch/decode/execute/writeback FSM with fetch handshake

module decoder (
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic        alumux1,
  output logic        alumux2
);
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [3:0] ALU_PASSB  = 4'b1111;

  logic [2:0] funct3;

  always_comb begin
    funct3  = instr[14:12];
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    rd      = 5'd0;
    imm     = {{20{instr[31]}}, instr[31:20]};
    alu_op  = 4'b0000;
    alumux1 = 1'b0;
    alumux2 = 1'b1;
    // Unsupported opcodes keep rd=0 so they retire as no-ops.
    case (instr[6:0])
      OPC_OP_IMM: begin
        rd     = instr[11:7];
        alu_op = {(funct3 == 3'b101) && instr[30], funct3};
      end
      OPC_OP: begin
        rd      = instr[11:7];
        alumux2 = 1'b0;
        alu_op  = {((funct3 == 3'b000) || (funct3 == 3'b101)) && instr[30], funct3};
      end
      OPC_LUI: begin
        rd     = instr[11:7];
        imm    = {instr[31:12], 12'd0};
        alu_op = ALU_PASSB;
      end
      OPC_AUIPC: begin
        rd      = instr[11:7];
        imm     = {instr[31:12], 12'd0};
        alumux1 = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

module alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic signed [31:0] a_s;

  always_comb begin
    a_s = a;
    case (op)
      4'b0000: y = a + b;
      4'b1000: y = a - b;
      4'b0001: y = a << b[4:0];
      4'b0010: y = {31'd0, $signed(a) < $signed(b)};
      4'b0011: y = {31'd0, a < b};
      4'b0100: y = a ^ b;
      4'b0101: y = a >> b[4:0];
      4'b1101: y = a_s >>> b[4:0];
      4'b0110: y = a | b;
      4'b0111: y = a & b;
      4'b1111: y = b;
      default: y = a + b;
    endcase
  end
endmodule

module regfile (
  input  logic        clk,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] x1_data
);
  logic [31:0] regs [32];

  // No reset: architectural registers survive a core reset.
  always_ff @(posedge clk) begin
    if (write_addr != 5'd0) regs[write_addr] <= write_data;
  end

  assign read_data1 = (read_addr1 == 5'd0) ? 32'd0 : regs[read_addr1];
  assign read_data2 = (read_addr2 == 5'd0) ? 32'd0 : regs[read_addr2];
  assign x1_data    = regs[1];
endmodule

module multicycle_core #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          IMEM_AW  = 8,
  parameter int          TIMEOUT  = 16,
  parameter int          RET_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [31:0]        imem_data,
  input  logic               halt,
  input  logic               step,
  output logic [31:0]        pc_address,
  output logic [31:0]        alu_output,
  output logic [31:0]        reg1_output,
  output logic               retire,
  output logic [RET_W-1:0]   retired,
  output logic               halted,
  output logic               fault
);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT, S_FAULT
  } state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       ir;
  logic [31:0]       aluout;
  logic [WAIT_W-1:0] wait_cnt;

  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, rs1_data, rs2_data, op1, op2, alu_y;
  logic [3:0]  alu_op;
  logic        alumux1, alumux2;
  logic [4:0]  write_addr;

  decoder u_decoder (
    .instr(ir), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .alu_op(alu_op), .alumux1(alumux1), .alumux2(alumux2)
  );

  assign write_addr = (state == S_WRITEBACK) ? rd : 5'd0;

  regfile u_regfile (
    .clk(clk), .read_addr1(rs1), .read_addr2(rs2),
    .write_addr(write_addr), .write_data(aluout),
    .read_data1(rs1_data), .read_data2(rs2_data), .x1_data(reg1_output)
  );

  assign op1 = alumux1 ? pc : rs1_data;
  assign op2 = alumux2 ? imm : rs2_data;

  alu u_alu (.op(alu_op), .a(op1), .b(op2), .y(alu_y));

  // Gated by rst so the request drops during reset yet rises in the first cycle after release.
  assign imem_req   = rst && (state == S_FETCH);
  assign imem_addr  = pc[IMEM_AW+1:2];
  assign pc_address = pc;
  assign alu_output = aluout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      pc       <= PC_RESET;
      ir       <= 32'd0;
      aluout   <= 32'd0;
      retired  <= '0;
      retire   <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir       <= imem_data;
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            fault    <= 1'b1;
            state    <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          aluout <= alu_y;
          retire <= 1'b1;
          state  <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc      <= pc + PC_STEP;
          retired <= retired + 1'b1;
          if (halt) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state  <= S_FETCH;
          end
        end
        S_HALT: begin
          if (!halt || step) begin
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_FAULT: ;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - randomized self-checking bench for multicycle_core against an ISA-level model

module tb_multicycle_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        halt = 1'b0;
  logic        step = 1'b0;
  logic [31:0] pc_address, alu_output, reg1_output;
  logic        retire;
  logic [31:0] retired;
  logic        halted, fault;

  multicycle_core #(
    .PC_RESET(32'h0), .PC_STEP(32'd4), .IMEM_AW(8), .TIMEOUT(16), .RET_W(32)
  ) dut (
    .clk(clk), .rst(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .halt(halt), .step(step),
    .pc_address(pc_address), .alu_output(alu_output), .reg1_output(reg1_output),
    .retire(retire), .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_ret_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ret = 32'd0;
  logic [31:0] m_alu = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_regs[r];
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic [4:0] sh;
    sx = x;
    sh = y[4:0];
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: if (alt) return sx >>> sh; else return x >> sh;
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  // RV32I semantics of the instruction at model pc, applied to model state.
  task automatic model_exec(input logic [31:0] ins);
    logic [31:0] a, b, i_imm, u_imm, res;
    logic [2:0] f3;
    a = reg_val(ins[19:15]);
    b = reg_val(ins[24:20]);
    f3 = ins[14:12];
    i_imm = {{20{ins[31]}}, ins[31:20]};
    u_imm = {ins[31:12], 12'd0};
    case (ins[6:0])
      7'h13: res = alu_ref(f3, (f3 == 3'd5) && ins[30], a, i_imm);
      7'h33: res = alu_ref(f3, ins[30], a, b);
      7'h37: res = u_imm;
      default: res = m_pc + u_imm;
    endcase
    if (ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    m_alu = res;
    m_pc = m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] rnd;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic alt;
    logic [11:0] imm12;
    rnd = $urandom;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = rnd[2:0];
    alt = rnd[3];
    case ($urandom_range(0, 3))
      0: begin
        if (f3 == 3'd1) imm12 = {7'd0, rnd[8:4]};
        else if (f3 == 3'd5) imm12 = {1'b0, alt, 5'd0, rnd[8:4]};
        else imm12 = rnd[31:20];
        return {imm12, rs1, f3, rd, 7'h13};
      end
      1: begin
        if (f3 != 3'd0 && f3 != 3'd5) alt = 1'b0;
        return {1'b0, alt, 5'd0, rs2, rs1, f3, rd, 7'h33};
      end
      2: return {rnd[31:12], rd, 7'h37};
      default: return {rnd[31:12], rd, 7'h17};
    endcase
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int waits, input bit gap_chk);
    int n;
    logic [7:0] a0;
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc[9:2]);
    a0 = imem_addr;
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      imem_data = $urandom;
      @(negedge clk);
      chk("wait_addr", imem_addr, a0);
      chk("wait_req", imem_req, 1);
    end
    imem_valid = 1'b1;
    imem_data = ins;
    @(negedge clk);
    imem_valid = 1'($urandom_range(0, 1));
    imem_data = $urandom;
    chk("dec_retire", retire, 0);
    chk("dec_req", imem_req, 0);
    @(negedge clk);
    imem_valid = 1'($urandom_range(0, 1));
    chk("exe_retire", retire, 0);
    @(negedge clk);
    imem_valid = 1'b0;
    chk("wb_retire", retire, 1);
    if (gap_chk) chk("retire_gap", 32'(cyc - last_ret_cyc), 32'(4 + waits));
    last_ret_cyc = cyc;
    model_exec(ins);
    @(negedge clk);
    chk("post_retire", retire, 0);
    chk("pc", pc_address, m_pc);
    chk("retired", retired, m_ret);
    chk("alu_output", alu_output, m_alu);
    chk("reg1", reg1_output, m_regs[1]);
    chk("no_fault", fault, 0);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] pc_frozen, ret_frozen;
    int n;

    // Reset state with imem_valid held high.
    imem_valid = 1'b1;
    imem_data = 32'h0050_0093;
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc_address, 32'h0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_alu", alu_output, 0);
    chk("rst_retire", retire, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;
    #1;
    chk("first_req", imem_req, 1);

    run_instr(32'h0050_0093, 0, 1'b0);
    chk("tp_addi_x1", reg1_output, 32'd5);
    chk("tp_addi_pc", pc_address, 32'd4);
    chk("tp_addi_ret", retired, 32'd1);
    run_instr(32'h0000_1097, 0, 1'b1);
    chk("tp_auipc_x1", reg1_output, 32'h1004);
    chk("tp_auipc_alu", alu_output, 32'h1004);
    chk("tp_auipc_ret", retired, 32'd2);

    // Withheld valid: 3 wait cycles per fetch.
    run_instr(32'h0010_8093, 3, 1'b1);
    run_instr(32'h0010_8093, 3, 1'b1);

    for (int r = 2; r < 8; r++) begin
      rnd = $urandom;
      run_instr({rnd[31:12], 5'(r), 7'h37}, 0, 1'b1);
      rnd = $urandom;
      run_instr({rnd[31:20], 5'(r), 3'd0, 5'(r), 7'h13}, 0, 1'b1);
    end

    // Random program; step toggles freely and must be ignored while running.
    for (int k = 0; k < 40; k++) begin
      step = 1'($urandom_range(0, 1));
      run_instr(gen_instr(), (k == 20) ? 15 : int'($urandom_range(0, 4)), 1'b1);
    end
    step = 1'b0;

    // Halt mid-instruction, single-step, resume.
    halt = 1'b1;
    run_instr(gen_instr(), 1, 1'b1);
    chk("halted", halted, 1);
    chk("halted_req", imem_req, 0);
    repeat (3) begin
      @(negedge clk);
      chk("halt_noretire", retire, 0);
      chk("halt_pc", pc_address, m_pc);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_unhalt", halted, 0);
    run_instr(gen_instr(), 0, 1'b0);
    chk("step_rehalt", halted, 1);
    repeat (2) begin
      @(negedge clk);
      chk("step_one_only", retire, 0);
    end
    halt = 1'b0;
    run_instr(gen_instr(), 0, 1'b0);
    run_instr(gen_instr(), 2, 1'b1);
    chk("resume_halted", halted, 0);

    // Reset during EXECUTE of addi x1,x0,7 after x1 holds 3.
    run_instr(32'h0030_0093, 0, 1'b1);
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    imem_valid = 1'b1;
    imem_data = 32'h0070_0093;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_pc", pc_address, 32'h0);
    chk("mid_rst_ret", retired, 0);
    chk("mid_rst_alu", alu_output, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_x1", reg1_output, 32'd3);
    chk("mid_rst_fetch", imem_req, 1);
    m_pc = 32'h0;
    m_ret = 32'd0;
    m_alu = 32'd0;
    run_instr(32'h0070_0093, 0, 1'b0);
    chk("after_rst_x1", reg1_output, 32'd7);

    // Fetch timeout: 16 FETCH cycles without valid.
    pc_frozen = m_pc;
    ret_frozen = m_ret;
    imem_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_timeout_fault", fault, 0);
    chk("pre_timeout_req", imem_req, 1);
    @(negedge clk);
    chk("timeout_fault", fault, 1);
    chk("timeout_req", imem_req, 0);
    imem_valid = 1'b1;
    imem_data = 32'h0050_0093;
    repeat (5) begin
      @(negedge clk);
      chk("fault_noretire", retire, 0);
    end
    chk("fault_sticky", fault, 1);
    chk("fault_pc", pc_address, pc_frozen);
    chk("fault_ret", retired, ret_frozen);
    chk("fault_x1", reg1_output, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("fault_cleared", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
